// File: rtl/axis_frame_rr_arbiter_if.sv
// AXI-Stream bundle for the frame round-robin arbiter: N packed source ports plus one merged master port.
// master = arbiter view, slave = the surrounding sources/sink.
interface axis_frame_rr_arbiter_if #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1
);
   logic [N*DATA_WIDTH-1:0] s_axis_tdata;
   logic [N-1:0]            s_axis_tvalid;
   logic [N-1:0]            s_axis_tready;
   logic [N-1:0]            s_axis_tlast;
   logic [N*USER_WIDTH-1:0] s_axis_tuser;
   logic [DATA_WIDTH-1:0]   m_axis_tdata;
   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic                    m_axis_tlast;
   logic [USER_WIDTH-1:0]   m_axis_tuser;

   modport master (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );

   modport slave (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );
endinterface

// File: rtl/axis_frame_rr_arbiter.sv
// Frame-granular round-robin arbiter merging N AXI-Stream sources onto one registered master port.
// Over-long frames are cut at MAX_BEATS, marked bad via tuser[0] and the remainder drained.
module axis_frame_rr_arbiter #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1,
   parameter int MAX_BEATS  = 2048
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axis_frame_rr_arbiter_if.master axis,
   output logic [$clog2(N)-1:0]   grant_idx,
   output logic                   busy,
   output logic                   trunc_pulse
);
   localparam int GW = $clog2(N);
   localparam int CW = $clog2(MAX_BEATS + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PASS  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]            state;
   logic [CW-1:0]         beat_cnt;
   logic                  out_free;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [USER_WIDTH-1:0] sel_user;
   logic                  accept;
   logic                  at_max;
   logic                  arb_found;
   logic [GW-1:0]         arb_idx;
   logic [GW-1:0]         cand_idx;
   int unsigned           cand;

   assign out_free  = !axis.m_axis_tvalid || axis.m_axis_tready;
   assign sel_valid = axis.s_axis_tvalid[grant_idx];
   assign sel_last  = axis.s_axis_tlast[grant_idx];
   assign sel_data  = axis.s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
   assign sel_user  = axis.s_axis_tuser[grant_idx*USER_WIDTH +: USER_WIDTH];
   assign at_max    = (beat_cnt + CW'(1)) == CW'(MAX_BEATS);
   assign busy      = (state != ST_IDLE);
   assign accept    = sel_valid && axis.s_axis_tready[grant_idx];

   always_comb begin
      axis.s_axis_tready = '0;
      if (state == ST_PASS)
         axis.s_axis_tready[grant_idx] = out_free;
      else if (state == ST_DRAIN)
         axis.s_axis_tready[grant_idx] = 1'b1;
   end

   // Scan grant_idx+1 .. grant_idx+N with an explicit wrap so non-power-of-two N works.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = grant_idx;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = 32'(grant_idx) + i;
         if (cand >= N)
            cand = cand - N;
         cand_idx = GW'(cand);
         if (!arb_found && axis.s_axis_tvalid[cand_idx]) begin
            arb_found = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         grant_idx          <= GW'(N - 1);
         beat_cnt           <= '0;
         trunc_pulse        <= 1'b0;
         axis.m_axis_tvalid <= 1'b0;
         axis.m_axis_tdata  <= '0;
         axis.m_axis_tlast  <= 1'b0;
         axis.m_axis_tuser  <= '0;
      end else begin
         trunc_pulse <= 1'b0;
         if (axis.m_axis_tvalid && axis.m_axis_tready)
            axis.m_axis_tvalid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (arb_found) begin
                  grant_idx <= arb_idx;
                  beat_cnt  <= '0;
                  state     <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (accept) begin
                  beat_cnt           <= beat_cnt + CW'(1);
                  axis.m_axis_tvalid <= 1'b1;
                  axis.m_axis_tdata  <= sel_data;
                  axis.m_axis_tlast  <= sel_last || at_max;
                  axis.m_axis_tuser  <= (at_max && !sel_last) ? (sel_user | USER_WIDTH'(1)) : sel_user;
                  if (sel_last) begin
                     state <= ST_IDLE;
                  end else if (at_max) begin
                     state       <= ST_DRAIN;
                     trunc_pulse <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (accept && sel_last)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Directed, table-driven bench for axis_frame_rr_arbiter (N=4, MAX_BEATS=4),
// plus hand sequences for output back-pressure and mid-frame reset.
module tb_axis_frame_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int UW = 1;
   localparam int MB = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] grant_idx;
   logic       busy;
   logic       trunc_pulse;

   axis_frame_rr_arbiter_if #(.N(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)) axis_bus ();

   axis_frame_rr_arbiter #(.N(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BEATS(MB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .axis       (axis_bus),
      .grant_idx  (grant_idx),
      .busy       (busy),
      .trunc_pulse(trunc_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      bit         do_rst;
      logic [3:0] s_valid;
      logic [31:0] s_data;
      logic [3:0] s_last;
      logic [3:0] s_user;
      logic       m_ready;
      logic [3:0] e_s_ready;
      logic       e_m_valid;
      logic [7:0] e_m_data;
      logic       e_m_last;
      logic       e_m_user;
      logic [1:0] e_grant;
      logic       e_busy;
      logic       e_trunc;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string tag, input bit do_rst, input logic [3:0] sv, input logic [31:0] sd,
                          input logic [3:0] sl, input logic [3:0] su, input logic mr,
                          input logic [3:0] esr, input logic emv, input logic [7:0] emd, input logic eml,
                          input logic emu, input logic [1:0] eg, input logic eb, input logic et);
      vec_t v;
      v.tag = tag; v.do_rst = do_rst; v.s_valid = sv; v.s_data = sd; v.s_last = sl; v.s_user = su;
      v.m_ready = mr; v.e_s_ready = esr; v.e_m_valid = emv; v.e_m_data = emd; v.e_m_last = eml;
      v.e_m_user = emu; v.e_grant = eg; v.e_busy = eb; v.e_trunc = et;
      vecs.push_back(v);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      axis_bus.s_axis_tvalid = '0;
      axis_bus.s_axis_tdata  = '0;
      axis_bus.s_axis_tlast  = '0;
      axis_bus.s_axis_tuser  = '0;
      axis_bus.m_axis_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [8:0] got[$];
      logic [8:0] prev_out;
      logic       prev_stall;
      int         beat;

      rst_n = 1'b0;
      // Single source 2, 3-beat frame; tuser on beat 2 must pass through.
      add_vec("t1", 1, 4'b0100, 32'h00A1_0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd3, 0, 0);
      add_vec("t1", 0, 4'b0100, 32'h00A1_0000, 4'b0000, 4'b0000, 1, 4'b0100, 0, 8'h00, 0, 0, 2'd2, 1, 0);
      add_vec("t1", 0, 4'b0100, 32'h00A2_0000, 4'b0000, 4'b0100, 1, 4'b0100, 1, 8'hA1, 0, 0, 2'd2, 1, 0);
      add_vec("t1", 0, 4'b0100, 32'h00A3_0000, 4'b0100, 4'b0000, 1, 4'b0100, 1, 8'hA2, 0, 1, 2'd2, 1, 0);
      add_vec("t1", 0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'hA3, 1, 0, 2'd2, 0, 0);
      add_vec("t1", 0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd2, 0, 0);
      // All sources valid, 2-beat frames: grants 0,1,2,3,0 with one idle cycle between frames.
      add_vec("t2", 1, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd3, 0, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0001, 0, 8'h00, 0, 0, 2'd0, 1, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 8'h00, 0, 0, 2'd0, 1, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h01, 1, 0, 2'd0, 0, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0010, 0, 8'h00, 0, 0, 2'd1, 1, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1100, 4'b0010, 4'b0000, 1, 4'b0010, 1, 8'h10, 0, 0, 2'd1, 1, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h11, 1, 0, 2'd1, 0, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0100, 0, 8'h00, 0, 0, 2'd2, 1, 0);
      add_vec("t2", 0, 4'b1111, 32'h3021_1000, 4'b0100, 4'b0000, 1, 4'b0100, 1, 8'h20, 0, 0, 2'd2, 1, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h21, 1, 0, 2'd2, 0, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b1000, 0, 8'h00, 0, 0, 2'd3, 1, 0);
      add_vec("t2", 0, 4'b1111, 32'h3120_1000, 4'b1000, 4'b0000, 1, 4'b1000, 1, 8'h30, 0, 0, 2'd3, 1, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h31, 1, 0, 2'd3, 0, 0);
      add_vec("t2", 0, 4'b1111, 32'h3020_1000, 4'b0000, 4'b0000, 1, 4'b0001, 0, 8'h00, 0, 0, 2'd0, 1, 0);
      // Source 1 sends 7 beats: 4 forwarded (4th marked), 3 drained, then source 2 wins.
      add_vec("t4", 1, 4'b0110, 32'h002F_4100, 4'b0100, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd3, 0, 0);
      add_vec("t4", 0, 4'b0110, 32'h002F_4100, 4'b0100, 4'b0000, 1, 4'b0010, 0, 8'h00, 0, 0, 2'd1, 1, 0);
      add_vec("t4", 0, 4'b0110, 32'h002F_4200, 4'b0100, 4'b0000, 1, 4'b0010, 1, 8'h41, 0, 0, 2'd1, 1, 0);
      add_vec("t4", 0, 4'b0110, 32'h002F_4300, 4'b0100, 4'b0000, 1, 4'b0010, 1, 8'h42, 0, 0, 2'd1, 1, 0);
      add_vec("t4", 0, 4'b0110, 32'h002F_4400, 4'b0100, 4'b0000, 1, 4'b0010, 1, 8'h43, 0, 0, 2'd1, 1, 0);
      add_vec("t4", 0, 4'b0110, 32'h002F_4500, 4'b0100, 4'b0000, 1, 4'b0010, 1, 8'h44, 1, 1, 2'd1, 1, 1);
      add_vec("t4", 0, 4'b0110, 32'h002F_4600, 4'b0100, 4'b0000, 1, 4'b0010, 0, 8'h00, 0, 0, 2'd1, 1, 0);
      add_vec("t4", 0, 4'b0110, 32'h002F_4700, 4'b0110, 4'b0000, 1, 4'b0010, 0, 8'h00, 0, 0, 2'd1, 1, 0);
      add_vec("t4", 0, 4'b0100, 32'h002F_0000, 4'b0100, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd1, 0, 0);
      add_vec("t4", 0, 4'b0100, 32'h002F_0000, 4'b0100, 4'b0000, 1, 4'b0100, 0, 8'h00, 0, 0, 2'd2, 1, 0);
      add_vec("t4", 0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h2F, 1, 0, 2'd2, 0, 0);
      // Exactly MAX_BEATS beats with last on the final one: legal, unmarked, no drain.
      add_vec("t5", 1, 4'b0001, 32'h0000_0051, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd3, 0, 0);
      add_vec("t5", 0, 4'b0001, 32'h0000_0051, 4'b0000, 4'b0000, 1, 4'b0001, 0, 8'h00, 0, 0, 2'd0, 1, 0);
      add_vec("t5", 0, 4'b0001, 32'h0000_0052, 4'b0000, 4'b0000, 1, 4'b0001, 1, 8'h51, 0, 0, 2'd0, 1, 0);
      add_vec("t5", 0, 4'b0001, 32'h0000_0053, 4'b0000, 4'b0000, 1, 4'b0001, 1, 8'h52, 0, 0, 2'd0, 1, 0);
      add_vec("t5", 0, 4'b0001, 32'h0000_0054, 4'b0001, 4'b0000, 1, 4'b0001, 1, 8'h53, 0, 0, 2'd0, 1, 0);
      add_vec("t5", 0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h54, 1, 0, 2'd0, 0, 0);
      add_vec("t5", 0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         string p;
         p = $sformatf("%s[%0d]", vecs[i].tag, i);
         if (vecs[i].do_rst)
            apply_reset();
         else begin
            @(posedge clk);
            #1;
         end
         axis_bus.s_axis_tvalid = vecs[i].s_valid;
         axis_bus.s_axis_tdata  = vecs[i].s_data;
         axis_bus.s_axis_tlast  = vecs[i].s_last;
         axis_bus.s_axis_tuser  = vecs[i].s_user;
         axis_bus.m_axis_tready = vecs[i].m_ready;
         @(negedge clk);
         check({p, " s_ready"}, 32'(axis_bus.s_axis_tready), 32'(vecs[i].e_s_ready));
         check({p, " m_valid"}, 32'(axis_bus.m_axis_tvalid), 32'(vecs[i].e_m_valid));
         check({p, " grant"},   32'(grant_idx),              32'(vecs[i].e_grant));
         check({p, " busy"},    32'(busy),                   32'(vecs[i].e_busy));
         check({p, " trunc"},   32'(trunc_pulse),            32'(vecs[i].e_trunc));
         if (vecs[i].e_m_valid) begin
            check({p, " m_data"}, 32'(axis_bus.m_axis_tdata), 32'(vecs[i].e_m_data));
            check({p, " m_last"}, 32'(axis_bus.m_axis_tlast), 32'(vecs[i].e_m_last));
            check({p, " m_user"}, 32'(axis_bus.m_axis_tuser), 32'(vecs[i].e_m_user));
         end
      end

      // Back-pressure: 4-beat frame from source 3 with m_axis_tready toggling 1,0,1,0...
      apply_reset();
      beat       = 0;
      prev_stall = 1'b0;
      prev_out   = '0;
      for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
         end
         axis_bus.m_axis_tready = (cyc % 2 == 0);
         axis_bus.s_axis_tvalid = (beat < 4) ? 4'b1000 : 4'b0000;
         axis_bus.s_axis_tdata  = {8'h61 + 8'(beat), 24'h0};
         axis_bus.s_axis_tlast  = (beat == 3) ? 4'b1000 : 4'b0000;
         @(negedge clk);
         if (prev_stall)
            check($sformatf("t3 stall hold cyc%0d", cyc),
                  {22'd0, axis_bus.m_axis_tvalid, axis_bus.m_axis_tlast, axis_bus.m_axis_tdata},
                  {22'd0, 1'b1, prev_out});
         if (axis_bus.m_axis_tvalid && axis_bus.m_axis_tready)
            got.push_back({axis_bus.m_axis_tlast, axis_bus.m_axis_tdata});
         prev_stall = axis_bus.m_axis_tvalid && !axis_bus.m_axis_tready;
         prev_out   = {axis_bus.m_axis_tlast, axis_bus.m_axis_tdata};
         if (axis_bus.s_axis_tready[3] && axis_bus.s_axis_tvalid[3])
            beat++;
      end
      check("t3 beat count", 32'(got.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         logic [8:0] exp_b;
         exp_b = {(k == 3), 8'h61 + 8'(k)};
         check($sformatf("t3 beat%0d", k), (k < got.size()) ? 32'(got[k]) : 32'h1FF_FFFF, 32'(exp_b));
      end

      // Asynchronous reset on beat 2 of a frame from source 0 (source 1 also valid).
      apply_reset();
      axis_bus.s_axis_tvalid = 4'b0011;
      axis_bus.s_axis_tdata  = 32'h0000_8171;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      axis_bus.s_axis_tdata = 32'h0000_8172;
      check("t6 mid-frame busy",    32'(busy),                   32'd1);
      check("t6 mid-frame m_valid", 32'(axis_bus.m_axis_tvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6 rst m_valid", 32'(axis_bus.m_axis_tvalid), 32'd0);
      check("t6 rst s_ready", 32'(axis_bus.s_axis_tready), 32'd0);
      check("t6 rst busy",    32'(busy),                   32'd0);
      check("t6 rst grant",   32'(grant_idx),              32'd3);
      check("t6 rst m_data",  32'(axis_bus.m_axis_tdata),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("t6 regrant idx",  32'(grant_idx),              32'd0);
      check("t6 regrant busy", 32'(busy),                   32'd1);
      check("t6 regrant rdy",  32'(axis_bus.s_axis_tready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
